// File: rtl/w_debounce.sv
// rtl/w_debounce.sv - two-flop synchronizer plus 4-state debounce FSM producing a clean w level and edge strobes
module w_debounce #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       w,
    output logic       w_rise,
    output logic       w_fall,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        LOW   = 2'b00,
        CHK_H = 2'b01,
        HIGH  = 2'b10,
        CHK_L = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // The first sample of a new level is taken in LOW/HIGH, so the check
    // states accept once cnt has reached DEBOUNCE-1 with the level still held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            w      <= 1'b0;
            w_rise <= 1'b0;
            w_fall <= 1'b0;
            state  <= LOW;
        end else begin
            s1     <= btn_raw;
            s2     <= s1;
            w_rise <= 1'b0;
            w_fall <= 1'b0;
            case (state)
                LOW: begin
                    if (s2) begin
                        state <= CHK_H;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                CHK_H: begin
                    if (!s2) begin
                        state  <= LOW;
                        cnt    <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= HIGH;
                        cnt    <= '0;
                        w      <= 1'b1;
                        w_rise <= 1'b1;
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state <= CHK_L;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                CHK_L: begin
                    if (s2) begin
                        state  <= HIGH;
                        cnt    <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= LOW;
                        cnt    <= '0;
                        w      <= 1'b0;
                        w_fall <= 1'b1;
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_w_debounce.sv
// tb/tb_w_debounce.sv - table-driven and sequence checks of w_debounce with DEBOUNCE=4
module tb_w_debounce;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       w;
    logic       w_rise;
    logic       w_fall;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    // exp packs {w, w_rise, w_fall, state[1:0]}
    typedef struct packed {
        logic       btn;
        logic       rst;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    w_debounce #(.DEBOUNCE(4), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .w        (w),
        .w_rise   (w_rise),
        .w_fall   (w_fall),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic b, input logic r, input logic [1:0] st,
                       input logic ew, input logic er, input logic ef);
        vec_t v;
        v.btn = b;
        v.rst = r;
        v.exp = {ew, er, ef, st};
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {w, w_rise, w_fall, state_dbg};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got w/rise/fall/state=%b required %b", name, act, exp);
        end
        checks++;
        if (w_rise && w_fall) begin
            errors++;
            $display("FAIL %s: w_rise and w_fall both high, required not both", name);
        end
    endtask

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        btn_raw = b;
        rst     = r;
        @(posedge clk);
        #1;
        if (w_rise) rise_cnt++;
        if (w_fall) fall_cnt++;
    endtask

    task automatic check_count(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    initial begin
        logic [8:0] pat;
        logic [1:0] pst [0:8];
        btn_raw = 1'b0;
        rst     = 1'b0;

        // reset and idle
        add(0,0,2'b00,0,0,0); add(0,0,2'b00,0,0,0);
        add(0,1,2'b00,0,0,0); add(0,1,2'b00,0,0,0);
        // clean rise: edge 6 after capture
        add(1,1,2'b00,0,0,0); add(1,1,2'b00,0,0,0);
        add(1,1,2'b01,0,0,0); add(1,1,2'b01,0,0,0); add(1,1,2'b01,0,0,0);
        add(1,1,2'b10,1,1,0); add(1,1,2'b10,1,0,0); add(1,1,2'b10,1,0,0);
        // clean fall
        add(0,1,2'b10,1,0,0); add(0,1,2'b10,1,0,0);
        add(0,1,2'b11,1,0,0); add(0,1,2'b11,1,0,0); add(0,1,2'b11,1,0,0);
        add(0,1,2'b00,0,0,1); add(0,1,2'b00,0,0,0);
        // two-cycle bounce rejected
        add(1,1,2'b00,0,0,0); add(1,1,2'b00,0,0,0);
        add(0,1,2'b01,0,0,0); add(0,1,2'b01,0,0,0);
        add(0,1,2'b00,0,0,0); add(0,1,2'b00,0,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].btn, tbl[i].rst);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end
        check_count("table_rise_count", rise_cnt, 1);
        check_count("table_fall_count", fall_cnt, 1);

        // bounce pattern 1,0,1,1,1,1 then held high
        rise_cnt = 0;
        pat = 9'b1_1111_1101;
        pst[0] = 2'b00; pst[1] = 2'b00; pst[2] = 2'b01; pst[3] = 2'b00;
        pst[4] = 2'b01; pst[5] = 2'b01; pst[6] = 2'b01; pst[7] = 2'b10;
        pst[8] = 2'b10;
        for (int k = 0; k < 9; k++) begin
            step(pat[k], 1'b1);
            check($sformatf("bounce_e%0d", k + 1),
                  {(k >= 7), (k == 7), 1'b0, pst[k]});
        end
        check_count("bounce_rise_count", rise_cnt, 1);

        // return to LOW through reset, then abort a check mid-count
        step(1'b0, 1'b0);
        check("reset_from_high", 5'b00000);
        step(1'b0, 1'b1);
        rise_cnt = 0;
        step(1'b1, 1'b1); check("mid_e1", 5'b00000);
        step(1'b1, 1'b1); check("mid_e2", 5'b00000);
        step(1'b1, 1'b1); check("mid_e3", 5'b00001);
        step(1'b1, 1'b1); check("mid_e4_cnt2", 5'b00001);
        step(1'b1, 1'b0); check("mid_reset", 5'b00000);

        // release with input held high: one rise six edges later, then quiet
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b1);
            if (k <= 2)      check($sformatf("rel_e%0d", k), 5'b00000);
            else if (k <= 5) check($sformatf("rel_e%0d", k), 5'b00001);
            else if (k == 6) check($sformatf("rel_e%0d", k), 5'b11010);
            else             check($sformatf("rel_e%0d", k), 5'b10010);
        end
        check_count("release_rise_count", rise_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w_debounce.md
W_DEBOUNCE -- requirements
Module: w_debounce

Purpose: input conditioner sitting directly upstream of the w-sampling sequence-detector FSM; turns an asynchronous, bouncy raw input into a clean, clk-synchronous w level plus edge strobes.

Interface
REQ-001 Parameter DEBOUNCE, default 4, meaning: consecutive equal synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, meaning: stability counter width; SHALL satisfy 2^CNT_W > DEBOUNCE-1.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 btn_raw  input  1  asynchronous raw input, may bounce.
REQ-006 w  output  1  debounced level, registered; feeds the downstream detector's w input.
REQ-007 w_rise  output  1  one-cycle strobe, registered, marking acceptance of a 0->1 change.
REQ-008 w_fall  output  1  one-cycle strobe, registered, marking acceptance of a 1->0 change.
REQ-009 state_dbg  output  2  current FSM state encoding, for observation only.

Function
REQ-010 The block SHALL pass btn_raw through two flops, s1 then s2; only s2 SHALL feed the FSM and the counter.
REQ-011 The FSM SHALL have 4 states: LOW=2'b00, CHK_H=2'b01, HIGH=2'b10, CHK_L=2'b11; state_dbg SHALL equal the state register.
REQ-012 In LOW: w=0; s2=1 -> CHK_H with cnt<=1; s2=0 -> stay, cnt<=0.
REQ-013 In CHK_H, when s2=0: -> LOW with cnt<=0 and no strobe (glitch rejected).
REQ-014 In CHK_H, when s2=1 and cnt==DEBOUNCE-1: -> HIGH with w<=1 and w_rise<=1.
REQ-015 In CHK_H, when s2=1 and cnt<DEBOUNCE-1: stay, cnt<=cnt+1.
REQ-016 HIGH and CHK_L SHALL mirror LOW and CHK_H with polarity inverted; acceptance in CHK_L sets w<=0 and w_fall<=1.
REQ-017 A level change SHALL be accepted only after exactly DEBOUNCE consecutive equal s2 samples, the first taken in LOW or HIGH.
REQ-018 Latency: w SHALL change after the (DEBOUNCE+2)th rising edge, counting the first edge that captures the new btn_raw level into s1 as edge 1.
REQ-019 w_rise and w_fall SHALL each be high for exactly one cycle per accepted change, SHALL never be high together, and SHALL be 0 in every other cycle.
REQ-020 w SHALL hold its value in both CHK states; it SHALL change only on an accepted transition.
REQ-021 A stable input SHALL produce no strobes and no counter activity beyond cnt=0.
REQ-022 cnt SHALL never exceed DEBOUNCE-1 and SHALL never wrap.

Reset
REQ-023 While rst=0 at a rising edge: s1, s2, cnt, w, w_rise and w_fall SHALL be 0 and the state SHALL be LOW, with priority over all other logic.
REQ-024 Reset asserted in any state, including mid-count in CHK_H or CHK_L, SHALL abort the check with no strobe emitted.
REQ-025 After release with btn_raw held high, the block SHALL treat the input as a fresh 0->1 change: after a full debounce, w_rise pulses once.

Verification (DEBOUNCE=4)
REQ-026 btn_raw 0->1 and held, captured at edge 1 -> w=1 and w_rise=1 after edge 6; w_rise=0 after edge 7; state_dbg sequence 00,01,01,01,10.
REQ-027 btn_raw high for 2 cycles then low (bounce) -> w stays 0, no strobe, state returns to 00, cnt=0.
REQ-028 From HIGH, btn_raw 1->0 and held -> w=0 and w_fall=1 six edges after capture; w_rise stays 0 throughout.
REQ-029 Bounce pattern 1,0,1,1,1,1 (per clock) -> w rises only after the final four-sample run; exactly one w_rise.
REQ-030 rst=0 for one edge while in CHK_H with cnt=2 -> all outputs 0 and state 00 after that edge; no w_rise.
REQ-031 Reset released with btn_raw=1 -> a single w_rise six edges after release; nothing further while the input is held.
